sreg_cmd_arbiter: RTL and testbench
===================================

# sreg_cmd_arbiter

Two-requester command arbiter in front of `sreg_ctrl`, the pixel shift-register controller. Accepts commands (3-bit opcode plus 42-bit payload) from a configuration requester (port 0) and a readout sequencer (port 1), serialises them onto the single `sreg_ctrl` command handshake, and tracks each command to completion. Returns one tagged response per command, with captured read data or a timeout error. Keeps a PIX_READ … PIX_READ_END sequence atomic to one requester.

## Interface
- `DATA_W`, 42, payload / read-data width (pixel chain length)
- `CMD_W`, 3, opcode width
- `TIMEOUT_CYCLES`, 256, max cycles from acceptance by `sreg_ctrl` to completion; ≥ 2
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `r0_valid` / `r1_valid`  in  1  requester has a command
- `r0_ready` / `r1_ready`  out  1  command taken this cycle
- `r0_cmd` / `r1_cmd`  in  CMD_W  opcode (000 PIX_WRITE … 111 SREG_READ)
- `r0_data` / `r1_data`  in  DATA_W  payload
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  1  requester index the response belongs to
- `rsp_data`  out  DATA_W  read data; 0 for non-read opcodes and on error
- `rsp_err`  out  1  command timed out
- `cmd_valid`  out  1  to `sreg_ctrl`
- `cmd_ready`  in  1  from `sreg_ctrl`; low while busy
- `cmd`  out  CMD_W  to `sreg_ctrl`
- `data_in`  out  DATA_W  to `sreg_ctrl`
- `data_out`  in  DATA_W  from `sreg_ctrl`, valid when `cmd_ready` returns high
- `locked`  out  1  read lock held
- `busy`  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: choose a grant, drive the granted `rX_ready` combinationally high, and latch opcode, payload and id on the transfer edge; go to ISSUE. With no valid request, stay in IDLE.
- Grant rule:
  - If `locked`, only the lock owner is eligible.
  - Otherwise, if one requester is valid, grant it.
  - If both are valid, grant the one that is not `last_grant`.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- ISSUE: `cmd_valid`=1 with the latched `cmd`/`data_in`, held stable until `cmd_valid && cmd_ready` at an edge; then go to WAIT_BUSY and clear the timeout counter.
- WAIT_BUSY: wait for `cmd_ready`=0, then go to WAIT_DONE.
- WAIT_DONE: wait for `cmd_ready`=1. On that edge:
  - capture `data_out` into `rsp_data` if the opcode is 001 (PIX_READ) or 111 (SREG_READ), otherwise load 0;
  - go to RESP.
- RESP: `rsp_valid`=1 with `rsp_id`/`rsp_data`/`rsp_err` held until `rsp_valid && rsp_ready`; then go to IDLE.
- Lock:
  - Set when a granted PIX_READ (001) is accepted in IDLE; the owner is the granted id.
  - Cleared when the owner's PIX_READ_END (010) response transfers, or on any timeout.
  - A PIX_READ from the owner while locked keeps the lock.
- Timeout:
  - An 8-bit-or-wider counter (`$clog2(TIMEOUT_CYCLES+1)`) increments each cycle in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES, go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - `cmd_valid` stays low until the next IDLE grant.
  - ISSUE has no timeout.
- Every accepted command produces exactly one response, in order.

## Timing
- Reset values: every output 0 (`r0_ready`, `r1_ready`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_err`, `cmd_valid`, `cmd`, `data_in`, `locked`, `busy`); FSM in IDLE; `last_grant`=1.
- Request accepted at edge T0 → `cmd_valid` high from T0+1.
- `sreg_ctrl` handshake at edge T1 → `cmd_ready` is expected low at T1+1.
- Completion edge Tc (`cmd_ready` back high) → `rsp_valid` high from Tc+1.
- Minimum occupancy: 5 cycles per command.
- `rX_ready` is high only in IDLE and for at most one requester per cycle; a requester that drops `valid` before transfer loses nothing.
- `rsp_ready` held high in RESP → back in IDLE the next cycle, so a new grant is possible one cycle after the response transfer.
- Reset asserted mid-command: immediate return to reset values. The in-flight command is dropped with no response, and the lock is cleared.

## Test plan
- Single write: r0 PIX_WRITE (000), data `0x26B4B5F692B`; `sreg_ctrl` model busy 84 cycles → `cmd`=000, `data_in`=`0x26B4B5F692B`; one response with `rsp_id`=0, `rsp_data`=0, `rsp_err`=0.
- Read data: r1 SREG_READ (111); model returns `data_out`=`0x3FF00000AAA` → `rsp_id`=1, `rsp_data`=`0x3FF00000AAA`.
- Round-robin: r0 and r1 both valid continuously with writes → grant order 0, 1, 0, 1; four responses with matching ids.
- Lock: r1 issues PIX_READ, r0 holds valid with a write, then r1 issues PIX_WRITE and PIX_READ_END → `r0_ready` stays 0 and `locked`=1 until the PIX_READ_END response transfers; r0 is granted next.
- Timeout: `TIMEOUT_CYCLES`=16, model never raises `cmd_ready` after acceptance → `rsp_err`=1 and `rsp_data`=0 exactly 16 cycles after the handshake; `locked` cleared.
- Backpressure and reset: `rsp_ready`=0 for 10 cycles → response fields stable and no new grant; `rst_n` pulsed low during WAIT_DONE → all outputs 0 and no response produced.

Source files
------------

// File: rtl/sreg_cmd_arbiter.sv
// Two-requester command arbiter in front of sreg_ctrl: serialises commands, tracks each to
// completion or timeout, returns one tagged response each, and keeps PIX_READ..PIX_READ_END atomic.
module sreg_cmd_arbiter #(
  parameter int DATA_W         = 42,
  parameter int CMD_W          = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [CMD_W-1:0]  r0_cmd,
  input  logic [DATA_W-1:0] r0_data,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [CMD_W-1:0]  r1_cmd,
  input  logic [DATA_W-1:0] r1_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [CMD_W-1:0]  cmd,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              locked,
  output logic              busy
);

  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

  localparam logic [CMD_W-1:0] OP_PIX_READ     = CMD_W'(1);
  localparam logic [CMD_W-1:0] OP_PIX_READ_END = CMD_W'(2);
  localparam logic [CMD_W-1:0] OP_SREG_READ    = CMD_W'(7);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t            state_q, state_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              id_q, id_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              locked_q, locked_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              elig0, elig1, grant_any, grant_id, in_idle;
  logic [CMD_W-1:0]  sel_cmd;
  logic [DATA_W-1:0] sel_data;
  logic              is_read, timeout_hit;
  logic [CNT_W-1:0]  cnt_inc;

  // While locked only the owner is eligible; a tie goes to whoever was not granted last.
  assign elig0     = r0_valid && (!locked_q || !owner_q);
  assign elig1     = r1_valid && (!locked_q || owner_q);
  assign grant_any = elig0 || elig1;
  assign grant_id  = (elig0 && elig1) ? ~last_grant_q : elig1;
  assign in_idle   = (state_q == IDLE);
  assign r0_ready  = in_idle && grant_any && !grant_id;
  assign r1_ready  = in_idle && grant_any && grant_id;
  assign sel_cmd   = grant_id ? r1_cmd : r0_cmd;
  assign sel_data  = grant_id ? r1_data : r0_data;

  assign is_read     = (cmd_q == OP_PIX_READ) || (cmd_q == OP_SREG_READ);
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    data_in_d    = data_in_q;
    id_d         = id_q;
    cmd_valid_d  = cmd_valid_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    locked_d     = locked_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d      = ISSUE;
          cmd_d        = sel_cmd;
          data_in_d    = sel_data;
          id_d         = grant_id;
          last_grant_d = grant_id;
          cmd_valid_d  = 1'b1;
          busy_d       = 1'b1;
          if (sel_cmd == OP_PIX_READ) begin
            locked_d = 1'b1;
            owner_d  = grant_id;
          end
        end
      end
      ISSUE: begin
        if (cmd_valid_q && cmd_ready) begin
          state_d     = WAIT_BUSY;
          cmd_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end
      WAIT_BUSY: begin
        cnt_d = cnt_inc;
        if (timeout_hit) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          locked_d    = 1'b0;
        end else if (!cmd_ready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        cnt_d = cnt_inc;
        // A completion landing on the timeout cycle still counts as a completion.
        if (cmd_ready) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = is_read ? data_out : '0;
        end else if (timeout_hit) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          locked_d    = 1'b0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          if (locked_q && (owner_q == id_q) && (cmd_q == OP_PIX_READ_END)) begin
            locked_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      data_in_q    <= '0;
      id_q         <= 1'b0;
      cmd_valid_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      locked_q     <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      data_in_q    <= data_in_d;
      id_q         <= id_d;
      cmd_valid_q  <= cmd_valid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      locked_q     <= locked_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign data_in   = data_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign locked    = locked_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sreg_cmd_arbiter.sv
// Bench for sreg_cmd_arbiter: queued requesters, a behavioural sreg_ctrl and a transaction-level
// arbitration/response model; a second instance with a short timeout covers the error path.
module tb_sreg_cmd_arbiter;

  localparam int TO_MAIN = 256;
  localparam int TO_T    = 16;

  typedef struct packed {
    logic [2:0]  c;
    logic [41:0] d;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_valid = 1'b0, r1_valid = 1'b0;
  logic        r0_ready, r1_ready;
  logic [2:0]  r0_cmd = '0, r1_cmd = '0;
  logic [41:0] r0_data = '0, r1_data = '0;
  logic        rsp_valid, rsp_id, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [41:0] rsp_data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [2:0]  cmd;
  logic [41:0] data_in;
  logic [41:0] data_out = '0;
  logic        locked, busy;

  logic        t_r0_valid = 1'b0, t_r1_valid = 1'b0;
  logic        t_r0_ready, t_r1_ready;
  logic [2:0]  t_r0_cmd = '0, t_r1_cmd = '0;
  logic [41:0] t_r0_data = '0, t_r1_data = '0;
  logic        t_rsp_valid, t_rsp_id, t_rsp_err;
  logic        t_rsp_ready = 1'b0;
  logic [41:0] t_rsp_data;
  logic        t_cmd_valid;
  logic        t_cmd_ready = 1'b0;
  logic [2:0]  t_cmd;
  logic [41:0] t_data_in;
  logic [41:0] t_data_out = '0;
  logic        t_locked, t_busy;

  always #5 clk = ~clk;

  sreg_cmd_arbiter #(.DATA_W(42), .CMD_W(3), .TIMEOUT_CYCLES(TO_MAIN)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_cmd(r0_cmd), .r0_data(r0_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_cmd(r1_cmd), .r1_data(r1_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .data_in(data_in), .data_out(data_out), .locked(locked), .busy(busy)
  );

  sreg_cmd_arbiter #(.DATA_W(42), .CMD_W(3), .TIMEOUT_CYCLES(TO_T)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(t_r0_valid), .r0_ready(t_r0_ready), .r0_cmd(t_r0_cmd), .r0_data(t_r0_data),
    .r1_valid(t_r1_valid), .r1_ready(t_r1_ready), .r1_cmd(t_r1_cmd), .r1_data(t_r1_data),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_id(t_rsp_id), .rsp_data(t_rsp_data),
    .rsp_err(t_rsp_err), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd(t_cmd),
    .data_in(t_data_in), .data_out(t_data_out), .locked(t_locked), .busy(t_busy)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [41:0] rand42();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[41:0];
  endfunction

  // Requester queues and model state.
  req_t        pq0[$];
  req_t        pq1[$];
  int          cyc = 0;
  int          phase = 0;          // 0 idle, 1 issuing, 2 in sreg_ctrl, 3 response
  int          last_g = 1;
  bit          lock_on = 0;
  int          lock_own = 0;
  req_t        inf;
  int          inf_id = 0;
  int          hs_cyc = 0;
  int          exp_cyc = 0;
  logic [41:0] exp_data = '0;
  bit          exp_err = 0;
  int          sr_left = 0;
  logic [41:0] sr_dout = '0;
  int          sr_len_fix = 0;
  bit          dout_fix_en = 0;
  logic [41:0] dout_fix = '0;
  int          drop_pct = 0;
  int          stall_pct = 0;
  bit          bp_arm = 0;
  int          bp_left = 0;
  logic [7:0]  glog = '0;
  int          gcount = 0;
  int          ntx = 0;

  task automatic push(input int p, input logic [2:0] c, input logic [41:0] d);
    req_t r;
    r.c = c;
    r.d = d;
    if (p == 0) pq0.push_back(r);
    else pq1.push_back(r);
  endtask

  task automatic cycle();
    logic [1:0] exp_g;
    bit e0, e1;
    int g, n;
    @(negedge clk);
    cyc++;
    r0_valid = (pq0.size() != 0) && ($urandom_range(0, 99) >= drop_pct);
    r1_valid = (pq1.size() != 0) && ($urandom_range(0, 99) >= drop_pct);
    if (pq0.size() != 0) begin r0_cmd = pq0[0].c; r0_data = pq0[0].d; end
    if (pq1.size() != 0) begin r1_cmd = pq1[0].c; r1_data = pq1[0].d; end
    cmd_ready = (sr_left == 0);
    data_out  = cmd_ready ? sr_dout : rand42();
    if (phase == 3 && bp_left > 0) begin
      rsp_ready = 1'b0;
      bp_left--;
    end else begin
      rsp_ready = ($urandom_range(0, 99) >= stall_pct);
    end
    #1;
    exp_g = 2'b00;
    g = 0;
    if (phase == 0) begin
      e0 = r0_valid && (!lock_on || lock_own == 0);
      e1 = r1_valid && (!lock_on || lock_own == 1);
      if (e0 && e1) g = 1 - last_g;
      else g = e1 ? 1 : 0;
      if (e0 || e1) exp_g = (g == 1) ? 2'b10 : 2'b01;
    end
    check("ready", 64'({r1_ready, r0_ready}), 64'(exp_g));
    check("busy", 64'(busy), 64'(phase != 0));
    check("locked", 64'(locked), 64'(lock_on));
    check("cmd_valid", 64'(cmd_valid), 64'(phase == 1));
    if (phase == 1) check("cmd_payload", 64'({cmd, data_in}), 64'({inf.c, inf.d}));
    if (phase == 3)
      check("rsp", 64'({rsp_valid, rsp_id, rsp_err, rsp_data}),
            64'({1'b1, inf_id[0], exp_err, exp_data}));
    else
      check("rsp_valid", 64'(rsp_valid), 64'(0));

    if (sr_left > 0) sr_left--;
    case (phase)
      0: if (exp_g != 2'b00) begin
        if (g == 0) inf = pq0.pop_front();
        else inf = pq1.pop_front();
        inf_id = g;
        last_g = g;
        if (inf.c == 3'd1) begin lock_on = 1; lock_own = g; end
        if (gcount < 8) glog[gcount] = g[0];
        gcount++;
        sr_left = $urandom_range(0, 2);
        phase = 1;
      end
      1: if (cmd_ready) begin
        n = (sr_len_fix > 0) ? sr_len_fix : int'($urandom_range(1, 20));
        sr_left = n;
        sr_dout = dout_fix_en ? dout_fix : rand42();
        hs_cyc = cyc;
        if (n + 1 <= TO_MAIN) begin
          exp_cyc  = cyc + n + 2;
          exp_err  = 0;
          exp_data = (inf.c == 3'd1 || inf.c == 3'd7) ? sr_dout : 42'd0;
        end else begin
          exp_cyc  = cyc + TO_MAIN + 1;
          exp_err  = 1;
          exp_data = '0;
        end
        phase = 2;
      end
      2: if (cyc + 1 == exp_cyc) begin
        phase = 3;
        if (exp_err) lock_on = 0;
        if (bp_arm) begin bp_left = 10; bp_arm = 0; end
      end
      3: if (rsp_ready) begin
        $display("rsp #%0d id=%0d cmd=%0d data=%h err=%0d cyc=%0d",
                 ntx, inf_id, inf.c, exp_data, exp_err, cyc);
        if (inf.c == 3'd2 && lock_on && lock_own == inf_id) lock_on = 0;
        ntx++;
        phase = 0;
      end
      default: phase = 0;
    endcase
  endtask

  task automatic run_drain(input int budget);
    int n = 0;
    while ((pq0.size() != 0 || pq1.size() != 0 || phase != 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drained", 64'(pq0.size() == 0 && pq1.size() == 0 && phase == 0), 64'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_ready = 1'b0;
    #1;
    check("reset_ctrl", 64'({r0_ready, r1_ready, rsp_valid, rsp_id, rsp_err, cmd_valid,
                             locked, busy, cmd}), 64'(0));
    check("reset_rsp_data", 64'(rsp_data), 64'(0));
    check("reset_data_in", 64'(data_in), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    phase = 0;
    lock_on = 0;
    last_g = 1;
    sr_left = 0;
  endtask

  initial begin
    int n;
    int waited;
    logic [41:0] td;

    do_reset();

    // Single write with an 84-cycle busy period.
    sr_len_fix = 84;
    push(0, 3'd0, 42'h26B4B5F692B);
    run_drain(300);

    // Register read returning a fixed pattern.
    sr_len_fix = 0;
    dout_fix_en = 1;
    dout_fix = 42'h3FF00000AAA;
    push(1, 3'd7, rand42());
    run_drain(100);
    dout_fix_en = 0;

    // Round-robin with both ports continuously valid.
    glog = '0;
    gcount = 0;
    for (int i = 0; i < 2; i++) begin
      push(0, 3'd0, rand42());
      push(1, 3'd0, rand42());
    end
    run_drain(300);
    check("rr_order", 64'(glog[3:0]), 64'(4'b1010));

    // Lock: r1 opens a read sequence, r0 waits until PIX_READ_END completes.
    glog = '0;
    gcount = 0;
    push(1, 3'd1, rand42());
    push(1, 3'd0, rand42());
    push(1, 3'd2, rand42());
    n = 0;
    while (phase == 0 && n < 50) begin cycle(); n++; end
    push(0, 3'd0, rand42());
    run_drain(400);
    check("lock_order", 64'(glog[3:0]), 64'(4'b0111));

    // Response backpressure while both ports wait.
    bp_arm = 1;
    push(0, 3'd3, rand42());
    push(1, 3'd4, rand42());
    run_drain(300);

    // Randomised traffic with read-lock bursts.
    drop_pct = 30;
    stall_pct = 30;
    for (int i = 0; i < 150; i++) begin
      int p, k;
      int r;
      p = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) begin
        push(p, 3'd1, rand42());
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) begin
          r = $urandom_range(0, 6);
          push(p, (r <= 1) ? 3'(r) : 3'(r + 1), rand42());
        end
        push(p, 3'd2, rand42());
      end else begin
        r = $urandom_range(0, 6);
        push(p, (r == 0) ? 3'd0 : 3'(r + 1), rand42());
      end
    end
    run_drain(40000);
    drop_pct = 0;
    stall_pct = 0;

    // Reset asserted during WAIT_DONE of a locked read: dropped, no response, lock gone.
    sr_len_fix = 40;
    push(0, 3'd1, rand42());
    n = 0;
    while (!(phase == 2 && cyc >= hs_cyc + 3) && n < 100) begin cycle(); n++; end
    check("reached_wait_done", 64'(phase == 2), 64'(1));
    check("lock_before_reset", 64'(locked), 64'(1));
    do_reset();
    repeat (30) cycle();
    sr_len_fix = 0;
    push(0, 3'd0, rand42());
    run_drain(100);

    // Timeout path on the short-timeout instance: sreg_ctrl never completes.
    do_reset();
    td = rand42();
    @(negedge clk);
    t_r0_valid = 1'b1;
    t_r0_cmd = 3'd1;
    t_r0_data = td;
    t_cmd_ready = 1'b1;
    #1;
    check("to_grant", 64'({t_r1_ready, t_r0_ready}), 64'(2'b01));
    @(negedge clk);
    t_r0_valid = 1'b0;
    #1;
    check("to_issue", 64'({t_cmd_valid, t_cmd, t_data_in}), 64'({1'b1, 3'd1, td}));
    check("to_locked", 64'(t_locked), 64'(1));
    @(negedge clk);
    t_cmd_ready = 1'b0;
    #1;
    waited = 1;
    while (!t_rsp_valid && waited < 40) begin
      check("to_wait", 64'({t_cmd_valid, t_locked, t_busy}), 64'(3'b011));
      @(negedge clk);
      #1;
      waited++;
    end
    check("to_latency", 64'(waited - 1), 64'(TO_T));
    check("to_rsp", 64'({t_rsp_valid, t_rsp_id, t_rsp_err, t_rsp_data}),
          64'({1'b1, 1'b0, 1'b1, 42'd0}));
    check("to_unlocked", 64'(t_locked), 64'(0));
    $display("rsp timeout id=0 cmd=1 err=%0d after %0d cycles", t_rsp_err, waited - 1);
    t_rsp_ready = 1'b1;
    @(negedge clk);
    t_rsp_ready = 1'b0;
    #1;
    check("to_idle", 64'({t_rsp_valid, t_cmd_valid, t_busy, t_locked}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
